// File: rtl/halfband_2nd_interp.sv
// Second 2x halfband interpolator: filter-branch sample from one time-shared MAC,
// centre-tap sample from the delay line scaled by 0.5.
module halfband_2nd_interp #(
  parameter int WIDTH = 18,
  parameter int NPAIR = 4,
  parameter int ACCW  = 40
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic signed [WIDTH-1:0] x_in,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid,
  output logic                    y_phase,
  output logic                    busy,
  output logic                    overrun
);
  localparam int TAPS = 2 * NPAIR;
  localparam int KW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int IW   = $clog2(TAPS);
  localparam int PW   = WIDTH + 1;
  localparam int MW   = PW + WIDTH;

  typedef enum logic [1:0] {IDLE, MAC, EMIT0, EMIT1} state_t;

  state_t                  state, next_state;
  logic [KW-1:0]           k;
  logic signed [WIDTH-1:0] x [TAPS];
  logic signed [ACCW-1:0]  acc;
  logic                    accept, drop, mac_step, emit0, emit1;

  logic [IW-1:0]           k_lo, k_hi;
  logic signed [PW-1:0]    pair_sum;
  logic signed [MW-1:0]    product;
  logic                    acc_unused;

  function automatic logic signed [WIDTH-1:0] coef(input logic [KW-1:0] idx);
    case (idx)
      KW'(0):  coef = WIDTH'(-174);
      KW'(1):  coef = WIDTH'(1638);
      KW'(2):  coef = WIDTH'(-7962);
      KW'(3):  coef = WIDTH'(39268);
      default: coef = '0;
    endcase
  endfunction

  // Symmetric pair k uses taps k and TAPS-1-k.
  assign k_lo     = IW'(k);
  assign k_hi     = IW'(TAPS - 1) - IW'(k);
  assign pair_sum = PW'(x[k_lo]) + PW'(x[k_hi]);
  assign product  = MW'(pair_sum) * MW'(coef(k));

  // Only acc[2*WIDTH-2:WIDTH-1] forms the output; the rest is headroom and fraction.
  assign acc_unused = ^{acc[ACCW-1:2*WIDTH-1], acc[WIDTH-2:0]};

  assign busy = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drop       = 1'b0;
    mac_step   = 1'b0;
    emit0      = 1'b0;
    emit1      = 1'b0;
    case (state)
      IDLE: begin
        if (in_en) begin
          accept     = 1'b1;
          next_state = MAC;
        end
      end
      MAC: begin
        drop     = in_en;
        mac_step = 1'b1;
        if (k == KW'(NPAIR - 1)) next_state = EMIT0;
      end
      EMIT0: begin
        drop       = in_en;
        emit0      = 1'b1;
        next_state = EMIT1;
      end
      EMIT1: begin
        emit1 = 1'b1;
        if (in_en) begin
          accept     = 1'b1;
          next_state = MAC;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: the delay line is reset explicitly because its taps feed the outputs
  // directly; an unreset history would leak into the first results after reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      acc     <= '0;
      k       <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      y_phase <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= emit0 | emit1;
      if (drop) overrun <= 1'b1;

      if (accept) begin
        x[0] <= x_in;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        acc <= '0;
        k   <= '0;
      end else if (mac_step) begin
        acc <= acc + ACCW'(product);
        k   <= k + KW'(1);
      end

      if (emit0) begin
        y       <= acc[2*WIDTH-2:WIDTH-1];
        y_phase <= 1'b0;
      end else if (emit1) begin
        // NOTE: non-blocking assignment means this reads x[NPAIR-1] from before
        // any shift accepted on the same edge, which is the intended centre value.
        y       <= x[NPAIR-1] >>> 1;
        y_phase <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_halfband_2nd_interp.sv
// Directed bench for halfband_2nd_interp: impulse, DC, back-to-back, overrun and
// mid-operation reset, with hand-computed expected values.
module tb_halfband_2nd_interp;
  logic               clk = 1'b0;
  logic               rst;
  logic               in_en;
  logic signed [17:0] x_in;
  logic signed [17:0] y;
  logic               y_valid;
  logic               y_phase;
  logic               busy;
  logic               overrun;

  int total = 0;
  int bad   = 0;

  halfband_2nd_interp dut (
    .sys_clk (clk),
    .reset   (rst),
    .in_en   (in_en),
    .x_in    (x_in),
    .y       (y),
    .y_valid (y_valid),
    .y_phase (y_phase),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one in_en strobe; returns at the negedge following the sampling edge.
  task automatic send(input logic signed [17:0] v);
    @(negedge clk);
    in_en = 1'b1;
    x_in  = v;
    @(negedge clk);
    in_en = 1'b0;
  endtask

  // Wait (bounded) for the phase-0 strobe and capture both output samples.
  task automatic get_pair(output logic signed [17:0] y0, output logic signed [17:0] y1,
                          output int lat, output logic ok);
    lat = 0;
    while (y_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    ok = (y_valid === 1'b1) && (y_phase === 1'b0);
    y0 = y;
    @(negedge clk);
    ok = ok && (y_valid === 1'b1) && (y_phase === 1'b1);
    y1 = y;
  endtask

  initial begin
    int                 imp0[8] = '{-87, 819, -3981, 19634, 19634, -3981, 819, -87};
    logic signed [17:0] y0, y1;
    int                 lat;
    logic               ok;
    int                 seen;

    rst   = 1'b1;
    in_en = 1'b0;
    x_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_y", y, 0);
    check("rst_valid", y_valid, 0);
    check("rst_phase", y_phase, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    // Impulse at spacing 8.
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 18'h10000 : 18'h00000);
      if (i == 0) check("busy_after_accept", busy, 1);
      get_pair(y0, y1, lat, ok);
      if (i == 0) check("latency", lat, 5);
      check($sformatf("imp%0d_strobes", i), ok, 1);
      check($sformatf("imp%0d_p0", i), y0, imp0[i]);
      check($sformatf("imp%0d_p1", i), y1, (i == 3) ? 32768 : 0);
    end
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Positive and negative full-scale DC.
    for (int i = 0; i < 8; i++) begin
      send(18'h1FFFF);
      get_pair(y0, y1, lat, ok);
      check($sformatf("dcp%0d_strobes", i), ok, 1);
      if (i == 7) begin
        check("dcp_p0", y0, 65539);
        check("dcp_p1", y1, 65535);
      end
    end
    for (int i = 0; i < 8; i++) begin
      send(18'h20000);
      get_pair(y0, y1, lat, ok);
      check($sformatf("dcn%0d_strobes", i), ok, 1);
      if (i == 7) begin
        check("dcn_p0", y0, -65540);
        check("dcn_p1", y1, -65536);
      end
    end

    // Clear the delay line, then impulse back-to-back at spacing 6.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in_en = 1'b1;
      x_in  = (i == 0) ? 18'h10000 : 18'h00000;
      @(negedge clk);
      in_en = 1'b0;
      if (i > 0) begin
        check($sformatf("b2b%0d_c0_valid", i), y_valid, 1);
        check($sformatf("b2b%0d_c0_phase", i), y_phase, 1);
        check($sformatf("b2b%0d_prev_p1", i), y, (i == 4) ? 32768 : 0);
      end else begin
        check("b2b0_c0_valid", y_valid, 0);
      end
      for (int c = 1; c < 5; c++) begin
        @(negedge clk);
        check($sformatf("b2b%0d_c%0d_valid", i, c), y_valid, 0);
        check($sformatf("b2b%0d_c%0d_busy", i, c), busy, 1);
      end
      @(negedge clk);
      check($sformatf("b2b%0d_c5_valid", i), y_valid, 1);
      check($sformatf("b2b%0d_c5_phase", i), y_phase, 0);
      check($sformatf("b2b%0d_p0", i), y, imp0[i]);
    end
    @(negedge clk);
    check("b2b_last_valid", y_valid, 1);
    check("b2b_last_phase", y_phase, 1);
    check("b2b_last_p1", y, 0);
    check("b2b_no_overrun", overrun, 0);

    // Overrun: in_en at E2 is dropped; in-flight result unchanged.
    send(18'h10000);
    @(negedge clk);
    in_en = 1'b1;
    x_in  = 18'd100000;
    @(negedge clk);
    in_en = 1'b0;
    check("ovr_set", overrun, 1);
    get_pair(y0, y1, lat, ok);
    check("ovr_strobes", ok, 1);
    check("ovr_latency", lat, 3);
    check("ovr_p0", y0, -87);
    check("ovr_p1", y1, 0);
    send(18'h00000);
    get_pair(y0, y1, lat, ok);
    check("ovr_next_p0", y0, 819);
    check("ovr_sticky", overrun, 1);

    // Reset at E3 of an operation.
    send(18'h10000);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_y", y, 0);
    check("mrst_valid", y_valid, 0);
    check("mrst_phase", y_phase, 0);
    check("mrst_busy", busy, 0);
    check("mrst_overrun", overrun, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (y_valid === 1'b1) seen++;
    end
    check("mrst_no_valid", seen, 0);
    send(18'h10000);
    get_pair(y0, y1, lat, ok);
    check("post_rst_strobes", ok, 1);
    check("post_rst_p0", y0, -87);
    check("post_rst_p1", y1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
